// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
// Latency: none; declarations only.
// Backpressure: none.
package rst_seq_pkg;

   // Sequencer states, in the order a sequence walks through them
   typedef enum logic [2:0] {
      IDLE,
      QUIESCE,
      PERP,
      HOLD,
      GAP,
      ACK
   } seq_state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_PERP_LEAD = 4;
   localparam int DEF_HOLD_CYC  = 16;
   localparam int DEF_REL_GAP   = 4;
   localparam int DEF_QTO_CYC   = 256;
   localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter shared by every timed phase of the reset sequence.
// Latency: load takes effect the next cycle; decrements by one per cycle and parks at zero.
// Backpressure: none; load has priority over counting.
module rst_seq_cnt #(
   parameter int               CNT_W   = 16,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             slowest_sync_clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   // Count down toward zero, reloading whenever the sequencer starts a new phase
   always_ff @(posedge slowest_sync_clk or negedge rstn) begin
      if (!rstn) begin
         value <= RST_VAL;
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - 1'b1;
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Agent reset sequencer: quiesce masters, drop perp then bus reset, release bus then perp, ack requesters.
// Latency: request -> quiesce_req in 2 cycles; ack -> perp low 1, bus low +PERP_LEAD, held HOLD_CYC, perp up +REL_GAP.
// Backpressure: stalls in QUIESCE until quiesce_ack (bounded by QTO_CYC when RST_SEQ_TIMEOUT_EN is defined); late requests queue.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int PERP_LEAD = DEF_PERP_LEAD,
   parameter int HOLD_CYC  = DEF_HOLD_CYC,
   parameter int REL_GAP   = DEF_REL_GAP,
   parameter int QTO_CYC   = DEF_QTO_CYC,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic               slowest_sync_clk,
   input  logic               rstn,
   input  logic [NUM_REQ-1:0] rst_req,
   input  logic               quiesce_ack,
   output logic               quiesce_req,
   output logic               perp_rst_n,
   output logic               bus_rst_n,
   output logic [NUM_REQ-1:0] req_ack,
   output logic [NUM_REQ-1:0] rst_cause,
   output logic               busy,
   output logic               qto_flag
);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t PERP_LD = cnt_t'(PERP_LEAD - 1);
   localparam cnt_t HOLD_LD = cnt_t'(HOLD_CYC - 1);
   localparam cnt_t GAP_LD  = cnt_t'(REL_GAP - 1);
   localparam longint CNT_SPAN = longint'(1) << CNT_W;
   localparam bit PARAMS_OK = (PERP_LEAD >= 1) && (HOLD_CYC >= 1) && (REL_GAP >= 1) && (QTO_CYC >= 1) &&
                              (longint'(PERP_LEAD) <= CNT_SPAN) && (longint'(HOLD_CYC) <= CNT_SPAN) &&
                              (longint'(REL_GAP) <= CNT_SPAN) && (longint'(QTO_CYC) <= CNT_SPAN);

   seq_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] pending;
   logic               idle_exit;
   logic               qto_hit;
   logic               cnt_load;
   cnt_t               cnt_ld_val;
   cnt_t               cnt_value;
   logic               cnt_zero;
   logic               quiesce_req_nxt, perp_nxt, bus_nxt, busy_nxt, qto_nxt;
   logic [NUM_REQ-1:0] req_ack_nxt, rst_cause_nxt;

   assign idle_exit = (state == IDLE) && (pending != '0);

`ifdef RST_SEQ_TIMEOUT_EN
   localparam cnt_t QTO_LD = cnt_t'(QTO_CYC - 1);
   logic q_first;

   // Marks the first QUIESCE cycle, where the timeout window is armed
   always_ff @(posedge slowest_sync_clk or negedge rstn) begin
      if (!rstn) q_first <= 1'b0;
      else       q_first <= idle_exit;
   end

   // Timeout wins only when the masters still have not acked
   assign qto_hit = (state == QUIESCE) && !q_first && cnt_zero && !quiesce_ack;
`else
   assign qto_hit = 1'b0;
`endif

   // Phase timer, reset into the power-on hold
   rst_seq_cnt #(
      .CNT_W   (CNT_W),
      .RST_VAL (HOLD_LD)
   ) u_cnt (
      .slowest_sync_clk (slowest_sync_clk),
      .rstn             (rstn),
      .load             (cnt_load),
      .load_val         (cnt_ld_val),
      .value            (cnt_value),
      .zero             (cnt_zero)
   );

   // Reload the timer on each phase change
   always_comb begin
      cnt_load   = 1'b0;
      cnt_ld_val = '0;
      case (state)
         QUIESCE: begin
            if (quiesce_ack || qto_hit) begin
               cnt_load   = 1'b1;
               cnt_ld_val = PERP_LD;
            end
`ifdef RST_SEQ_TIMEOUT_EN
            else if (q_first) begin
               cnt_load   = 1'b1;
               cnt_ld_val = QTO_LD;
            end
`endif
         end
         PERP: if (cnt_zero) begin
            cnt_load   = 1'b1;
            cnt_ld_val = HOLD_LD;
         end
         HOLD: if (cnt_zero) begin
            cnt_load   = 1'b1;
            cnt_ld_val = GAP_LD;
         end
         default: ;
      endcase
   end

   // Requests accumulate; on leaving IDLE only this cycle's arrivals carry over
   always_ff @(posedge slowest_sync_clk or negedge rstn) begin
      if (!rstn)          pending <= '0;
      else if (idle_exit) pending <= rst_req;
      else                pending <= pending | rst_req;
   end

   // State register; power-on starts in the hold phase
   always_ff @(posedge slowest_sync_clk or negedge rstn) begin
      if (!rstn) state <= HOLD;
      else       state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pending != '0)           state_nxt = QUIESCE;
         QUIESCE: if (quiesce_ack || qto_hit)  state_nxt = PERP;
         PERP:    if (cnt_zero)                state_nxt = HOLD;
         HOLD:    if (cnt_zero)                state_nxt = GAP;
         GAP:     if (cnt_zero)                state_nxt = ACK;
         ACK:                                  state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   // Output decode; busy drops one cycle after settling in IDLE with nothing pending
   always_comb begin
      quiesce_req_nxt = quiesce_req;
      perp_nxt        = perp_rst_n;
      bus_nxt         = bus_rst_n;
      rst_cause_nxt   = rst_cause;
      qto_nxt         = qto_flag;
      req_ack_nxt     = '0;
      busy_nxt        = 1'b1;
      case (state)
         IDLE: begin
            if (pending != '0) begin
               rst_cause_nxt   = pending;
               quiesce_req_nxt = 1'b1;
               qto_nxt         = 1'b0;
            end else begin
               busy_nxt = 1'b0;
            end
         end
         QUIESCE: if (quiesce_ack || qto_hit) begin
            perp_nxt = 1'b0;
            if (qto_hit) qto_nxt = 1'b1;
         end
         PERP: if (cnt_zero) bus_nxt = 1'b0;
         HOLD: if (cnt_zero) bus_nxt = 1'b1;
         GAP:  if (cnt_zero) begin
            perp_nxt        = 1'b1;
            quiesce_req_nxt = 1'b0;
         end
         ACK:  req_ack_nxt = rst_cause;
         default: ;
      endcase
   end

   // Registered outputs
   always_ff @(posedge slowest_sync_clk or negedge rstn) begin
      if (!rstn) begin
         quiesce_req <= 1'b0;
         perp_rst_n  <= 1'b0;
         bus_rst_n   <= 1'b0;
         req_ack     <= '0;
         rst_cause   <= '0;
         busy        <= 1'b1;
         qto_flag    <= 1'b0;
      end else begin
         quiesce_req <= quiesce_req_nxt;
         perp_rst_n  <= perp_nxt;
         bus_rst_n   <= bus_nxt;
         req_ack     <= req_ack_nxt;
         rst_cause   <= rst_cause_nxt;
         busy        <= busy_nxt;
         qto_flag    <= qto_nxt;
      end
   end

   // The timer is parked at zero whenever the sequencer is idle, and every phase length fits it
   a_cnt_idle: assert property (@(posedge slowest_sync_clk) disable iff (!rstn)
      (state == IDLE) |-> ((cnt_value == '0) && PARAMS_OK));

endmodule

// File: tb/tb_rst_seq_ctrl.sv
`timescale 1ns/1ps
module tb_rst_seq_ctrl;
   localparam int NR  = 4;
   localparam int PL  = 4;
   localparam int HC  = 16;
   localparam int RG  = 4;
   localparam int QTO = 8;
   localparam int T   = PL + HC + RG;
   localparam int UNK = 1 << 28;

   logic          slowest_sync_clk = 1'b0;
   logic          rstn = 1'b0;
   logic [NR-1:0] rst_req = '0;
   logic          quiesce_ack = 1'b1;
   logic          quiesce_req, perp_rst_n, bus_rst_n, busy, qto_flag;
   logic [NR-1:0] req_ack, rst_cause;

   always #5 slowest_sync_clk = ~slowest_sync_clk;

   rst_seq_ctrl #(
      .NUM_REQ (NR), .PERP_LEAD (PL), .HOLD_CYC (HC), .REL_GAP (RG), .QTO_CYC (QTO), .CNT_W (16)
   ) dut (
      .slowest_sync_clk (slowest_sync_clk),
      .rstn             (rstn),
      .rst_req          (rst_req),
      .quiesce_ack      (quiesce_ack),
      .quiesce_req      (quiesce_req),
      .perp_rst_n       (perp_rst_n),
      .bus_rst_n        (bus_rst_n),
      .req_ack          (req_ack),
      .rst_cause        (rst_cause),
      .busy             (busy),
      .qto_flag         (qto_flag)
   );

   int total = 0;
   int bad   = 0;
   int cyc;

   // cycle index = clock edges seen since rstn was released
   always @(posedge slowest_sync_clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: one sequence described by its quiesce_req start cycle s and perp-fall cycle r
   int            m_s, m_r;
   bit            m_qreq_on, m_qto;
   logic [NR-1:0] m_cause, m_pend;

   // Event log of output edges
   int            perp_fall = -1, perp_rise = -1, bus_fall = -1, bus_rise = -1;
   int            busy_fall = -1, qreq_rise = -1, ack_cnt = 0;
   logic [NR-1:0] ack_hist[$];
   bit            prev_perp, prev_bus, prev_busy, prev_qreq;

   int            c, a;
   bit            rk;
   logic [NR-1:0] e_ack;

   always @(negedge slowest_sync_clk) begin
      if (!rstn) begin
         chk("rst_perp", 32'(perp_rst_n), 0);
         chk("rst_bus", 32'(bus_rst_n), 0);
         chk("rst_qreq", 32'(quiesce_req), 0);
         chk("rst_ack", 32'(req_ack), 0);
         chk("rst_cause", 32'(rst_cause), 0);
         chk("rst_busy", 32'(busy), 1);
         chk("rst_qto", 32'(qto_flag), 0);
         // power-on behaves like a sequence whose perp fell PL cycles before release, without quiesce
         m_s = -PL - 1; m_r = -PL; m_qreq_on = 1'b0; m_qto = 1'b0; m_cause = '0; m_pend = '0;
         prev_perp = 1'b0; prev_bus = 1'b0; prev_busy = 1'b1; prev_qreq = 1'b0;
      end else begin
         c  = cyc;
         rk = (m_r != UNK);
         a  = m_r + T + 1;
         e_ack = (rk && c == a) ? m_cause : '0;
         chk("perp_rst_n", 32'(perp_rst_n), 32'(!(rk && c >= m_r && c < m_r + T)));
         chk("bus_rst_n", 32'(bus_rst_n), 32'(!(rk && c >= m_r + PL && c < m_r + PL + HC)));
         chk("req_ack", 32'(req_ack), 32'(e_ack));
         chk("quiesce_req", 32'(quiesce_req), 32'(m_qreq_on && c >= m_s && (!rk || c < m_r + T)));
         chk("busy", 32'(busy), 32'(c >= m_s && (!rk || c <= a)));
         chk("rst_cause", 32'(rst_cause), 32'(m_cause));
         chk("qto_flag", 32'(qto_flag), 32'(m_qto && rk && c >= m_r));

         if (perp_rst_n && !prev_perp)  perp_rise = c;
         if (!perp_rst_n && prev_perp)  perp_fall = c;
         if (bus_rst_n && !prev_bus)    bus_rise = c;
         if (!bus_rst_n && prev_bus)    bus_fall = c;
         if (!busy && prev_busy)        busy_fall = c;
         if (quiesce_req && !prev_qreq) qreq_rise = c;
         if (req_ack != '0) begin
            ack_cnt++;
            ack_hist.push_back(req_ack);
         end
         prev_perp = perp_rst_n; prev_bus = bus_rst_n; prev_busy = busy; prev_qreq = quiesce_req;

         if (!rk && c >= m_s) begin
            if (quiesce_ack) m_r = c + 1;
`ifdef RST_SEQ_TIMEOUT_EN
            else if (c == m_s + QTO) begin
               m_r   = c + 1;
               m_qto = 1'b1;
            end
`endif
         end
         if (rk && c >= a && m_pend != '0) begin
            m_s = c + 1; m_r = UNK; m_cause = m_pend; m_qto = 1'b0; m_qreq_on = 1'b1;
            m_pend = rst_req;
         end else begin
            m_pend = m_pend | rst_req;
         end
      end
   end

   int pc;
   int ack0;

   task automatic pulse(input logic [NR-1:0] v);
      @(posedge slowest_sync_clk); #1;
      rst_req = v;
      pc = cyc;
      @(posedge slowest_sync_clk); #1;
      rst_req = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      repeat (3) @(negedge slowest_sync_clk);
      while (busy && n < 3000) begin
         @(negedge slowest_sync_clk);
         n++;
      end
      #1;
      chk({name, "_idle"}, 32'(busy), 0);
   endtask

   task automatic wait_low(input string name, input bit want_bus);
      int n;
      n = 0;
      while ((want_bus ? bus_rst_n : perp_rst_n) && n < 200) begin
         @(negedge slowest_sync_clk);
         n++;
      end
      #1;
      chk(name, 32'(want_bus ? bus_rst_n : perp_rst_n), 0);
   endtask

   initial begin
      repeat (3) @(negedge slowest_sync_clk);
      #1 rstn = 1'b1;

      // power-on release
      repeat (30) @(negedge slowest_sync_clk);
      #1;
      chk("pon_bus_rise", 32'(bus_rise), 16);
      chk("pon_perp_rise", 32'(perp_rise), 20);
      chk("pon_busy_fall", 32'(busy_fall), 22);
      chk("pon_no_ack", 32'(ack_cnt), 0);

      // single request
      ack0 = ack_cnt;
      pulse(4'b0010);
      wait_idle("single");
      chk("single_qreq_lat", 32'(qreq_rise - pc), 2);
      chk("single_perp_lat", 32'(perp_fall - qreq_rise), 1);
      chk("single_perp_low", 32'(perp_rise - perp_fall), 24);
      chk("single_bus_low", 32'(bus_rise - bus_fall), 16);
      chk("single_ack_cnt", 32'(ack_cnt - ack0), 1);
      chk("single_ack_val", 32'(ack_hist[$]), 32'h2);
      chk("single_cause", 32'(rst_cause), 32'h2);

      // merged requests
      ack0 = ack_cnt;
      pulse(4'b1001);
      wait_idle("merged");
      chk("merged_ack_cnt", 32'(ack_cnt - ack0), 1);
      chk("merged_ack_val", 32'(ack_hist[$]), 32'h9);

      // request (twice) during HOLD of another sequence
      ack0 = ack_cnt;
      pulse(4'b0001);
      wait_low("mid_in_hold", 1'b1);
      pulse(4'b0100);
      pulse(4'b0100);
      wait_idle("mid");
      chk("mid_ack_cnt", 32'(ack_cnt - ack0), 2);
      chk("mid_ack_first", 32'(ack_hist[ack_hist.size() - 2]), 32'h1);
      chk("mid_ack_second", 32'(ack_hist[$]), 32'h4);
      chk("mid_cause", 32'(rst_cause), 32'h4);

      // masters never ack
      ack0 = ack_cnt;
      quiesce_ack = 1'b0;
      pulse(4'b0010);
`ifdef RST_SEQ_TIMEOUT_EN
      wait_idle("qto");
      chk("qto_perp_lat", 32'(perp_fall - qreq_rise), 9);
      chk("qto_flag_set", 32'(qto_flag), 1);
      chk("qto_ack_val", 32'(ack_hist[$]), 32'h2);
`else
      repeat (1000) @(negedge slowest_sync_clk);
      #1;
      chk("stuck_busy", 32'(busy), 1);
      chk("stuck_qreq", 32'(quiesce_req), 1);
      chk("stuck_perp", 32'(perp_rst_n), 1);
      chk("stuck_no_ack", 32'(ack_cnt - ack0), 0);
      // a brief ack is enough; dropping it afterwards changes nothing
      @(posedge slowest_sync_clk); #1 quiesce_ack = 1'b1;
      @(posedge slowest_sync_clk); #1 quiesce_ack = 1'b0;
      wait_idle("late_ack");
      chk("late_ack_val", 32'(ack_hist[$]), 32'h2);
      chk("late_ack_bus_low", 32'(bus_rise - bus_fall), 16);
`endif
      chk("qw_ack_cnt", 32'(ack_cnt - ack0), 1);
      quiesce_ack = 1'b1;

      // async reset while in PERP
      ack0 = ack_cnt;
      pulse(4'b0001);
      wait_low("ar_in_perp", 1'b0);
      chk("ar_bus_still_high", 32'(bus_rst_n), 1);
      @(negedge slowest_sync_clk); #2;
      rstn = 1'b0;
      #1;
      chk("ar_perp_now", 32'(perp_rst_n), 0);
      chk("ar_bus_now", 32'(bus_rst_n), 0);
      chk("ar_cause_now", 32'(rst_cause), 0);
      repeat (3) @(negedge slowest_sync_clk);
      #1 rstn = 1'b1;
      wait_idle("ar_pon");
      repeat (10) @(negedge slowest_sync_clk);
      #1;
      chk("ar_no_ack", 32'(ack_cnt - ack0), 0);
      chk("ar_pending_lost", 32'(busy), 0);
      chk("ar_bus_rise", 32'(bus_rise), 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
